// File: rtl/mem_req_ctrl.sv
// Clocked memory request controller: valid/ready request and response channels,
// byte-enabled writes, fixed read latency, range checking and saturating counters.

module mem_req_ctrl_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rdata
);
  // Storage is deliberately not reset so contents survive a controller reset.
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];
endmodule

module mem_req_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [CNT_W-1:0]    wr_cnt,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic [CNT_W-1:0]    err_cnt
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      LAT_INIT = 2'(RD_LAT - 1);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $fatal(1, "mem_req_ctrl: RD_LAT must be 1..4");
    end
    if (DATA_W % 8 != 0) begin : g_bad_dw
      $fatal(1, "mem_req_ctrl: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $fatal(1, "mem_req_ctrl: DEPTH must be 1..2**ADDR_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          lat_q, lat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    wr_q, wr_d, rd_q, rd_d, ec_q, ec_d;
  logic [NB-1:0]       lane_we;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   mem_rdata;
  logic                in_range;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign in_range = ({1'b0, req_addr} < DEPTH_C);
  // Single-cycle reads look up the live request address; delayed reads use the latched one.
  assign rd_idx   = (state_q == IDLE) ? req_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      mem_req_ctrl_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
        .clk   (clk),
        .we    (lane_we[gi]),
        .widx  (req_addr[IDX_W-1:0]),
        .wdata (req_wdata[8*gi +: 8]),
        .ridx  (rd_idx),
        .rdata (mem_rdata[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    ec_d      = ec_q;
    lane_we   = '0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b0;
          if (!in_range) begin
            err_d = 1'b1;
            ec_d  = sat_inc(ec_q);
          end else if (req_write) begin
            lane_we = req_be;
            wr_d    = sat_inc(wr_q);
          end else begin
            rd_d = sat_inc(rd_q);
            if (RD_LAT == 1) begin
              rdata_d = mem_rdata;
            end else begin
              state_d = RD_WAIT;
              lat_d   = LAT_INIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == 2'd1) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ec_q    <= ec_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign wr_cnt    = wr_q;
  assign rd_cnt    = rd_q;
  assign err_cnt   = ec_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl across five parameterisations sharing one stimulus bus.

module tb_mem_req_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  req_valid;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;
  wire  [4:0]  rdy, vld, err;
  wire  [7:0]  rd0, rd2, rd3, rd4;
  wire  [31:0] rd1;
  wire  [15:0] wc [5];
  wire  [15:0] rc [5];
  wire  [15:0] ec [5];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: 32-bit data, 2: RD_LAT=3, 3: DEPTH=200, 4: RD_LAT=4
  mem_req_ctrl u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(rdy[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0]), .rsp_valid(vld[0]),
    .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err[0]), .wr_cnt(wc[0]), .rd_cnt(rc[0]),
    .err_cnt(ec[0]));
  mem_req_ctrl #(.DATA_W(32)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(rdy[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[1]),
    .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(err[1]), .wr_cnt(wc[1]), .rd_cnt(rc[1]),
    .err_cnt(ec[1]));
  mem_req_ctrl #(.RD_LAT(3)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(rdy[2]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0]), .rsp_valid(vld[2]),
    .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err[2]), .wr_cnt(wc[2]), .rd_cnt(rc[2]),
    .err_cnt(ec[2]));
  mem_req_ctrl #(.DEPTH(200)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[3]), .req_ready(rdy[3]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0]), .rsp_valid(vld[3]),
    .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(err[3]), .wr_cnt(wc[3]), .rd_cnt(rc[3]),
    .err_cnt(ec[3]));
  mem_req_ctrl #(.RD_LAT(4)) u4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[4]), .req_ready(rdy[4]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0]), .rsp_valid(vld[4]),
    .rsp_ready(rsp_ready), .rsp_rdata(rd4), .rsp_err(err[4]), .wr_cnt(wc[4]), .rd_cnt(rc[4]),
    .err_cnt(ec[4]));

  function automatic logic [31:0] rdata_of(input int k);
    case (k)
      0:       return {24'h0, rd0};
      1:       return rd1;
      2:       return {24'h0, rd2};
      3:       return {24'h0, rd3};
      default: return {24'h0, rd4};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic send(input int k, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    chk($sformatf("req_ready idle u%0d", k), {31'h0, rdy[k]}, 32'h1);
    req_valid[k] = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_wdata    = d;
    req_be       = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_rsp(input int k, input int budget);
    int n = 0;
    while (!vld[k] && n < budget) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk($sformatf("rsp timeout u%0d", k), {31'h0, vld[k]}, 32'h1);
  endtask

  task automatic finish_rsp(input int k);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("rsp_valid drop u%0d", k), {31'h0, vld[k]}, 32'h0);
    chk($sformatf("req_ready back u%0d", k), {31'h0, rdy[k]}, 32'h1);
  endtask

  task automatic xfer(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
    send(k, w, a, d, be);
    wait_rsp(k, 8);
    chk($sformatf("rdata u%0d @%h", k, a), rdata_of(k), exp_rd);
    chk($sformatf("err u%0d @%h", k, a), {31'h0, err[k]}, {31'h0, exp_err});
    finish_rsp(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    req_valid = '0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", {31'h0, rdy[0]}, 32'h1);
    chk("reset rsp_valid", {31'h0, vld[0]}, 32'h0);
    chk("reset rdata", rdata_of(0), 32'h0);
    chk("reset err", {31'h0, err[0]}, 32'h0);
    chk("reset wr_cnt", {16'h0, wc[0]}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Write then read-back, response one cycle after accept
    send(0, 1'b1, 8'h42, 32'h5a, 4'h1);
    chk("wr rsp_valid N+1", {31'h0, vld[0]}, 32'h1);
    chk("wr rdata", rdata_of(0), 32'h0);
    chk("wr err", {31'h0, err[0]}, 32'h0);
    finish_rsp(0);
    send(0, 1'b0, 8'h42, 32'h0, 4'h0);
    chk("rd rsp_valid N+1", {31'h0, vld[0]}, 32'h1);
    chk("rd rdata", rdata_of(0), 32'h5a);
    finish_rsp(0);
    chk("wr_cnt u0", {16'h0, wc[0]}, 32'h1);
    chk("rd_cnt u0", {16'h0, rc[0]}, 32'h1);
    chk("err_cnt u0", {16'h0, ec[0]}, 32'h0);

    // Response back-pressure; request bus changes after accept are ignored
    send(0, 1'b1, 8'h22, 32'haa, 4'h1);
    req_addr = 8'h42; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("stall rsp_valid", {31'h0, vld[0]}, 32'h1);
      chk("stall req_ready", {31'h0, rdy[0]}, 32'h0);
      chk("stall rdata", rdata_of(0), 32'h0);
      chk("stall err", {31'h0, err[0]}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    finish_rsp(0);
    xfer(0, 1'b0, 8'h22, 32'h0, 4'h0, 32'haa, 1'b0);
    xfer(0, 1'b0, 8'h42, 32'h0, 4'h0, 32'h5a, 1'b0);

    // Byte-enable merge on 32-bit data, all-zero enables
    xfer(1, 1'b1, 8'h03, 32'h11223344, 4'hf, 32'h0, 1'b0);
    xfer(1, 1'b1, 8'h03, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    xfer(1, 1'b0, 8'h03, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    xfer(1, 1'b1, 8'h03, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xfer(1, 1'b0, 8'h03, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    chk("wr_cnt u1", {16'h0, wc[1]}, 32'h3);
    chk("rd_cnt u1", {16'h0, rc[1]}, 32'h2);

    // RD_LAT=3: exact latency, address latched at accept
    xfer(2, 1'b1, 8'h05, 32'h77, 4'h1, 32'h0, 1'b0);
    xfer(2, 1'b1, 8'h06, 32'h66, 4'h1, 32'h0, 1'b0);
    send(2, 1'b0, 8'h05, 32'h0, 4'h0);
    req_addr = 8'h06;
    chk("lat3 N+1 rsp_valid", {31'h0, vld[2]}, 32'h0);
    chk("lat3 N+1 req_ready", {31'h0, rdy[2]}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat3 N+2 rsp_valid", {31'h0, vld[2]}, 32'h0);
    chk("lat3 N+2 req_ready", {31'h0, rdy[2]}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat3 N+3 rsp_valid", {31'h0, vld[2]}, 32'h1);
    chk("lat3 rdata", rdata_of(2), 32'h77);
    finish_rsp(2);

    // DEPTH=200: out-of-range requests error out, last word still usable
    xfer(3, 1'b1, 8'hC8, 32'h55, 4'h1, 32'h0, 1'b1);
    xfer(3, 1'b0, 8'hC8, 32'h0, 4'h0, 32'h0, 1'b1);
    chk("err_cnt u3", {16'h0, ec[3]}, 32'h2);
    chk("wr_cnt u3", {16'h0, wc[3]}, 32'h0);
    chk("rd_cnt u3", {16'h0, rc[3]}, 32'h0);
    xfer(3, 1'b1, 8'hC7, 32'h3c, 4'h1, 32'h0, 1'b0);
    xfer(3, 1'b0, 8'hC7, 32'h0, 4'h0, 32'h3c, 1'b0);
    xfer(3, 1'b0, 8'hFF, 32'h0, 4'h0, 32'h0, 1'b1);
    chk("err_cnt u3 final", {16'h0, ec[3]}, 32'h3);

    // RD_LAT=4: asynchronous reset mid-wait drops the response, keeps memory
    xfer(4, 1'b1, 8'h09, 32'h99, 4'h1, 32'h0, 1'b0);
    send(4, 1'b0, 8'h09, 32'h0, 4'h0);
    chk("lat4 wait req_ready", {31'h0, rdy[4]}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst rsp_valid", {31'h0, vld[4]}, 32'h0);
    chk("async rst req_ready", {31'h0, rdy[4]}, 32'h1);
    chk("async rst wr_cnt", {16'h0, wc[4]}, 32'h0);
    chk("async rst rd_cnt", {16'h0, rc[4]}, 32'h0);
    chk("async rst err_cnt", {16'h0, ec[4]}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (vld[4]) seen++;
    end
    chk("late rsp after rst", seen, 32'h0);
    xfer(4, 1'b0, 8'h09, 32'h0, 4'h0, 32'h99, 1'b0);
    chk("rd_cnt u4 after rst", {16'h0, rc[4]}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Parametrised, clocked successor to the strobe-driven test memory.
- Replaces the race-prone "sample on start edge" scheme with a synchronous valid/ready request channel and a valid/ready response channel.
- Supports reads and writes, byte enables, configurable read latency, out-of-range error reporting and access counters.
- Sits between a bench/driver and its storage model; all inputs are sampled on clk, so there is no DUT/TEST race.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles, from request accept to rsp_valid; legal range 1..4.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i enables byte i.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address was out of range (addr >= DEPTH).
- wr_cnt  out  CNT_W  count of successful writes.
- rd_cnt  out  CNT_W  count of successful reads.
- err_cnt  out  CNT_W  count of errored requests.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All counters=0.
  - Memory array is not reset.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid && req_ready at a rising edge (cycle N).
  - Write, in range: at edge N, for each i with req_be[i]=1, mem[addr][8i+:8] <= wdata[8i+:8]; bytes with req_be[i]=0 are unchanged. Go to RESP with rdata=0, err=0. rsp_valid is high from cycle N+1.
  - Read, in range: if RD_LAT=1, capture mem[addr] into rsp_rdata and go to RESP (rsp_valid from N+1). Otherwise go to RD_WAIT with lat_cnt=RD_LAT-1.
  - Out of range, read or write: no memory access. Go to RESP with rdata=0, err=1 (rsp_valid from N+1).
- RD_WAIT:
  - req_ready=0.
  - lat_cnt decrements each cycle.
  - When lat_cnt reaches 1, capture mem[latched addr] and go to RESP, so rsp_valid is high from cycle N+RD_LAT.
- RESP:
  - req_ready=0; rsp_valid=1.
  - rsp_rdata and rsp_err stay stable until the handshake.
  - On rsp_ready=1, go to IDLE; rsp_valid is 0 in the next cycle.
  - Any number of rsp_ready=0 stall cycles is legal.
- Request latching:
  - Address, write flag and be/data are latched at accept.
  - Changes on req_* after accept have no effect.
- Throughput: at most one request per (RD_LAT+1) cycles for reads and one per 2 cycles for writes; no pipelining.
- Counters:
  - Update at accept time.
  - Saturate at 2**CNT_W-1; they never wrap.
  - Exactly one counter increments per accepted request.
- Read after write to the same address returns the merged data.
- A write with req_be all zero is a successful write: it counts in wr_cnt but changes no memory.
- Reset mid-operation:
  - In RD_WAIT or RESP, the pending response is discarded.
  - A write already committed at accept remains in memory.
  - Counters clear.
- DEPTH < 2**ADDR_W: addresses DEPTH..2**ADDR_W-1 produce an error response.
- Illegal parameters (RD_LAT outside 1..4, DATA_W%8 != 0, DEPTH > 2**ADDR_W): $fatal at elaboration.

Test Plan:
- Reset, then write addr=8'h42 data=8'h5a be=1, then read 8'h42 (RD_LAT=1) -> write response: rdata=0 err=0 at N+1; read response: rdata=8'h5a at N+1; wr_cnt=1, rd_cnt=1.
- Write 8'h22 data=8'haa, hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, fields stable, req_ready=0 throughout; rsp_valid drops the cycle after rsp_ready=1.
- DATA_W=32, write 32'h11223344 be=4'hf to addr 3, then 32'hAABBCCDD be=4'b0101, then read addr 3 -> rdata=32'h11BB33DD.
- RD_LAT=3, read addr 5 holding 8'h77 -> rsp_valid first high exactly 3 cycles after accept with rdata=8'h77; req_ready=0 in the intervening cycles.
- DEPTH=200, write to addr 8'hC8 then read it -> both responses err=1 rdata=0; err_cnt=2, wr_cnt=0; memory location untouched.
- Assert rst=0 asynchronously mid-RD_WAIT (RD_LAT=4) -> rsp_valid=0 immediately, req_ready=1, counters 0; no late response appears after release.
